// File: rtl/mask_result_monitor.sv
// Checks the VHDL and Verilog mask results against each other on every valid sample.
// It counts samples and mismatches, keeps a sticky error flag and captures the first failing sample.
module mask_result_monitor #(
  parameter int WIDTH       = 16,
  parameter int WARMUP      = 4,
  parameter int CNT_W       = 16,
  parameter int STOP_ON_ERR = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] o_vhdl,
  input  logic [WIDTH-1:0] o_verilog,
  output logic             err,
  output logic             halted,
  output logic             active,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cap_idx,
  output logic [WIDTH-1:0] cap_a,
  output logic [WIDTH-1:0] cap_diff
);

  typedef enum logic [1:0] {
    ST_WARM = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam state_t           START     = (WARMUP == 0) ? ST_RUN : ST_WARM;
  localparam int               WW        = (WARMUP > 1) ? $clog2(WARMUP) : 1;
  localparam logic [WW-1:0]    WARM_LAST = WW'((WARMUP > 0) ? WARMUP - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_next;
  logic [WW-1:0]    r_warm;
  logic             r_err;
  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [CNT_W-1:0] r_cap_idx;
  logic [WIDTH-1:0] r_cap_a;
  logic [WIDTH-1:0] r_cap_diff;
  logic             w_mismatch;
  logic             w_take;

  // in_valid alone qualifies a/o_vhdl/o_verilog; there is no backpressure, every valid beat is consumed.
  assign w_mismatch = (o_vhdl != o_verilog);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= START;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_take = 1'b0;
    if (clear) begin
      w_next = START;
    end else begin
      case (r_state)
        ST_WARM: if (r_warm == WARM_LAST) w_next = ST_RUN;
        ST_RUN: begin
          if (in_valid) begin
            w_take = 1'b1;
            if (w_mismatch && (STOP_ON_ERR != 0)) w_next = ST_HALT;
          end
        end
        ST_HALT: w_next = ST_HALT;
        default: w_next = START;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_warm <= '0;
    else if (clear)                r_warm <= '0;
    else if (r_state == ST_WARM)   r_warm <= r_warm + 1'b1;
  end

  // Captures are armed only while the sticky flag is clear, so the first mismatch wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err        <= 1'b0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_cap_idx    <= '0;
      r_cap_a      <= '0;
      r_cap_diff   <= '0;
    end else if (clear) begin
      r_err        <= 1'b0;
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_cap_idx    <= '0;
      r_cap_a      <= '0;
      r_cap_diff   <= '0;
    end else if (w_take) begin
      if (r_sample_cnt != CNT_MAX) r_sample_cnt <= r_sample_cnt + 1'b1;
      if (w_mismatch) begin
        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
        r_err <= 1'b1;
        if (!r_err) begin
          r_cap_idx  <= r_sample_cnt;
          r_cap_a    <= a;
          r_cap_diff <= o_vhdl ^ o_verilog;
        end
      end
    end
  end

  assign err        = r_err;
  assign halted     = (r_state == ST_HALT);
  assign active     = (r_state == ST_RUN);
  assign sample_cnt = r_sample_cnt;
  assign err_cnt    = r_err_cnt;
  assign cap_idx    = r_cap_idx;
  assign cap_a      = r_cap_a;
  assign cap_diff   = r_cap_diff;

endmodule

// File: tb/tb_mask_result_monitor.sv
// Bench for mask_result_monitor: three configurations share one stimulus stream and are
// checked every cycle against a counting model, plus literal expectations at key points.
module tb_mask_result_monitor;

  logic        clk;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] o_vhdl;
  logic [15:0] o_verilog;

  // dut0: WARMUP=4 CNT_W=16 STOP=0 ; dut1: WARMUP=4 CNT_W=16 STOP=1 ; dut2: WARMUP=0 CNT_W=4 STOP=0
  logic        e0, h0, ac0, e1, h1, ac1, e2, h2, ac2;
  logic [15:0] sc0, ec0, ci0, ca0, cd0;
  logic [15:0] sc1, ec1, ci1, ca1, cd1;
  logic [3:0]  sc2, ec2, ci2;
  logic [15:0] ca2, cd2;

  logic        d_err[3];
  logic        d_halt[3];
  logic        d_act[3];
  logic [15:0] d_scnt[3];
  logic [15:0] d_ecnt[3];
  logic [15:0] d_cidx[3];
  logic [15:0] d_ca[3];
  logic [15:0] d_cd[3];

  int n_chk = 0;
  int n_err = 0;

  // model state: edges spent warming, halt flag, true (unsaturated) counts, captures
  int          m_since[3];
  bit          m_halt[3];
  int          m_ns[3];
  int          m_ne[3];
  int          m_cidx[3];
  logic [15:0] m_ca[3];
  logic [15:0] m_cd[3];

  mask_result_monitor #(.WIDTH(16), .WARMUP(4), .CNT_W(16), .STOP_ON_ERR(0)) u_dut0 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .o_vhdl(o_vhdl),
    .o_verilog(o_verilog), .err(e0), .halted(h0), .active(ac0), .sample_cnt(sc0),
    .err_cnt(ec0), .cap_idx(ci0), .cap_a(ca0), .cap_diff(cd0));

  mask_result_monitor #(.WIDTH(16), .WARMUP(4), .CNT_W(16), .STOP_ON_ERR(1)) u_dut1 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .o_vhdl(o_vhdl),
    .o_verilog(o_verilog), .err(e1), .halted(h1), .active(ac1), .sample_cnt(sc1),
    .err_cnt(ec1), .cap_idx(ci1), .cap_a(ca1), .cap_diff(cd1));

  mask_result_monitor #(.WIDTH(16), .WARMUP(0), .CNT_W(4), .STOP_ON_ERR(0)) u_dut2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .a(a), .o_vhdl(o_vhdl),
    .o_verilog(o_verilog), .err(e2), .halted(h2), .active(ac2), .sample_cnt(sc2),
    .err_cnt(ec2), .cap_idx(ci2), .cap_a(ca2), .cap_diff(cd2));

  always_comb begin
    d_err[0] = e0;  d_halt[0] = h0;  d_act[0] = ac0;
    d_err[1] = e1;  d_halt[1] = h1;  d_act[1] = ac1;
    d_err[2] = e2;  d_halt[2] = h2;  d_act[2] = ac2;
    d_scnt[0] = sc0; d_ecnt[0] = ec0; d_cidx[0] = ci0; d_ca[0] = ca0; d_cd[0] = cd0;
    d_scnt[1] = sc1; d_ecnt[1] = ec1; d_cidx[1] = ci1; d_ca[1] = ca1; d_cd[1] = cd1;
    d_scnt[2] = {12'd0, sc2}; d_ecnt[2] = {12'd0, ec2}; d_cidx[2] = {12'd0, ci2};
    d_ca[2] = ca2; d_cd[2] = cd2;
  end

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int p_warm(input int i);
    return (i == 2) ? 0 : 4;
  endfunction

  function automatic int p_max(input int i);
    return (i == 2) ? 15 : 65535;
  endfunction

  function automatic bit p_stop(input int i);
    return (i == 1);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_zero(input int i);
    m_since[i] = 0;
    m_halt[i]  = 1'b0;
    m_ns[i]    = 0;
    m_ne[i]    = 0;
    m_cidx[i]  = 0;
    m_ca[i]    = 16'd0;
    m_cd[i]    = 16'd0;
  endtask

  task automatic model_step(input int i);
    if (clear) begin
      model_zero(i);
    end else if (!m_halt[i]) begin
      if (m_since[i] < p_warm(i)) begin
        m_since[i]++;
      end else if (in_valid) begin
        if (o_vhdl != o_verilog) begin
          if (m_ne[i] == 0) begin
            m_cidx[i] = sat(m_ns[i], p_max(i));
            m_ca[i]   = a;
            m_cd[i]   = o_vhdl ^ o_verilog;
          end
          m_ne[i]++;
          if (p_stop(i)) m_halt[i] = 1'b1;
        end
        m_ns[i]++;
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      for (int i = 0; i < 3; i++) begin
        if (rst) model_zero(i);
        else     model_step(i);
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic cmp(input string nm, input int i, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: got %h, expected %h at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic cmp_bit(input string nm, input int i, input logic got, input logic exp);
    cmp(nm, i, {15'd0, got}, {15'd0, exp});
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        cmp_bit("err", i, d_err[i], m_ne[i] != 0);
        cmp_bit("halted", i, d_halt[i], m_halt[i]);
        cmp_bit("active", i, d_act[i], !m_halt[i] && (m_since[i] >= p_warm(i)));
        cmp("sample_cnt", i, d_scnt[i], 16'(sat(m_ns[i], p_max(i))));
        cmp("err_cnt", i, d_ecnt[i], 16'(sat(m_ne[i], p_max(i))));
        cmp("cap_idx", i, d_cidx[i], 16'(m_cidx[i]));
        cmp("cap_a", i, d_ca[i], m_ca[i]);
        cmp("cap_diff", i, d_cd[i], m_cd[i]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic smp(input logic [15:0] av, input logic [15:0] vh, input logic [15:0] vl);
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b1; a = av; o_vhdl = vh; o_verilog = vl;
  endtask

  task automatic good();
    logic [15:0] r;
    r = 16'($urandom);
    smp(16'($urandom), r, r);
  endtask

  task automatic idle();
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    a = 16'($urandom); o_vhdl = 16'($urandom); o_verilog = 16'($urandom);
  endtask

  task automatic look();
    idle();
    #1;
  endtask

  task automatic warm();
    repeat (4) idle();
  endtask

  task automatic do_clear(input logic v, input logic [15:0] vh, input logic [15:0] vl);
    @(negedge clk);
    clear = 1'b1; in_valid = v; a = 16'hDEAD; o_vhdl = vh; o_verilog = vl;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst = 1'b0; clear = 1'b0; in_valid = 1'b0;
    a = 16'd0; o_vhdl = 16'd0; o_verilog = 16'd0;
    #1 rst = 1'b1;
    @(negedge clk);
    #1;
    cmp_bit("rst_err", 0, e0, 1'b0);
    cmp_bit("rst_active", 0, ac0, 1'b0);
    cmp("rst_sample_cnt", 0, sc0, 16'd0);
    cmp_bit("rst_active_nowarm", 2, ac2, 1'b1);

    // warm-up: mismatching samples on the first three edges are discarded
    rst = 1'b0;
    clear = 1'b0; in_valid = 1'b1; a = 16'h0001; o_vhdl = 16'h0000; o_verilog = 16'hFFFF;
    smp(16'h0001, 16'h0000, 16'hFFFF);
    smp(16'h0001, 16'h0000, 16'hFFFF);
    look();
    cmp_bit("warm_err", 0, e0, 1'b0);
    cmp("warm_sample_cnt", 0, sc0, 16'd0);
    cmp_bit("warm_active", 0, ac0, 1'b0);
    cmp("nowarm_err_cnt", 2, d_ecnt[2], 16'd3);
    cmp("nowarm_cap_diff", 2, cd2, 16'hFFFF);
    look();
    cmp_bit("run_active", 0, ac0, 1'b1);

    // ten matching samples
    repeat (10) smp(16'hFFFF, 16'hAAAA, 16'hAAAA);
    look();
    cmp("ten_sample_cnt", 0, sc0, 16'd10);
    cmp("ten_err_cnt", 0, ec0, 16'd0);
    cmp_bit("ten_err", 0, e0, 1'b0);

    // clear beats a simultaneous mismatching sample
    do_clear(1'b1, 16'h0000, 16'hFFFF);
    look();
    cmp_bit("clr_err", 0, e0, 1'b0);
    cmp("clr_sample_cnt", 0, sc0, 16'd0);
    cmp_bit("clr_err_nowarm", 2, e2, 1'b0);
    warm();

    // halt on first mismatch at idx 2
    for (int k = 0; k < 8; k++) begin
      if (k == 2) smp(16'h00F0, 16'h0F0F, 16'h0F00);
      else        good();
    end
    look();
    cmp_bit("halt_halted", 1, h1, 1'b1);
    cmp("halt_sample_cnt", 1, sc1, 16'd3);
    cmp("halt_err_cnt", 1, ec1, 16'd1);
    cmp("halt_cap_idx", 1, ci1, 16'd2);
    cmp("run_sample_cnt", 0, sc0, 16'd8);
    cmp("run_cap_diff", 0, cd0, 16'h000F);
    do_clear(1'b0, 16'h0000, 16'h0000);
    look();
    cmp_bit("unhalt_halted", 1, h1, 1'b0);
    cmp_bit("unhalt_active", 1, ac1, 1'b0);
    cmp("unhalt_sample_cnt", 1, sc1, 16'd0);
    cmp("unhalt_cap_idx", 1, ci1, 16'd0);
    warm();

    // first capture survives a later mismatch
    for (int k = 0; k < 8; k++) begin
      if (k == 5)      smp(16'h1234, 16'hAAAA, 16'hAAAB);
      else if (k == 7) smp(16'h5678, 16'h1111, 16'h2222);
      else             good();
    end
    look();
    cmp_bit("cap_err", 0, e0, 1'b1);
    cmp("cap_err_cnt", 0, ec0, 16'd2);
    cmp("cap_idx5", 0, ci0, 16'd5);
    cmp("cap_a1234", 0, ca0, 16'h1234);
    cmp("cap_diff1", 0, cd0, 16'h0001);
    cmp("stop_sample_cnt", 1, sc1, 16'd6);
    cmp("stop_err_cnt", 1, ec1, 16'd1);

    // saturation of the 4-bit counters
    do_clear(1'b0, 16'h0000, 16'h0000);
    look();
    warm();
    repeat (20) good();
    look();
    cmp("sat_sample_cnt", 2, d_scnt[2], 16'd15);
    cmp("sat_err_cnt", 2, d_ecnt[2], 16'd0);
    cmp("wide_sample_cnt", 0, sc0, 16'd20);
    smp(16'hBEEF, 16'h0000, 16'h8000);
    look();
    cmp("sat_cap_idx", 2, d_cidx[2], 16'd15);
    cmp("sat_cap_a", 2, ca2, 16'hBEEF);
    cmp("wide_cap_idx", 0, ci0, 16'd20);
    repeat (20) smp(16'($urandom), 16'h0000, 16'h0001);
    look();
    cmp("sat_err_cnt_full", 2, d_ecnt[2], 16'd15);
    cmp("wide_err_cnt", 0, ec0, 16'd21);
    cmp("model_true_cnt", 0, 16'(m_ns[0]), 16'd41);

    // async reset mid-run, clear with mismatch from RUN
    do_clear(1'b0, 16'h0000, 16'h0000);
    look();
    warm();
    good();
    do_clear(1'b1, 16'h0000, 16'hFFFF);
    look();
    cmp_bit("clrrun_err", 0, e0, 1'b0);
    cmp("clrrun_sample_cnt", 0, sc0, 16'd0);
    warm();
    repeat (7) good();
    look();
    cmp("pre_rst_sample_cnt", 0, sc0, 16'd7);
    #2 rst = 1'b1;
    #1;
    cmp("async_sample_cnt", 0, sc0, 16'd0);
    cmp_bit("async_active", 0, ac0, 1'b0);
    cmp("async_sample_cnt_nowarm", 2, d_scnt[2], 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      clear    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 2) != 0);
      a        = 16'($urandom);
      o_vhdl   = 16'($urandom);
      o_verilog = ($urandom_range(0, 7) == 0) ? (o_vhdl ^ (16'h0001 << $urandom_range(0, 15))) : o_vhdl;
      if ($urandom_range(0, 699) == 0) begin
        #3 rst = 1'b1;
        #4 rst = 1'b0;
      end
    end
    look();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
